// File: rtl/output_serializer_pkg.sv
// Shared types and constants for the output_serializer slice: FSM state encoding,
// default pixel width and a helper that sizes the column counter.
package output_serializer_pkg;

    localparam int PIX_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        TOP_A = 2'd0,
        TOP_B = 2'd1,
        BOT_A = 2'd2,
        BOT_B = 2'd3
    } state_t;

    // Column counter width, never narrower than one bit.
    function automatic int col_width(input int line_w);
        return (line_w > 1) ? $clog2(line_w) : 1;
    endfunction

endpackage

// File: rtl/output_serializer_line_pair_buf.sv
// Line buffer holding one source line of bottom-row pixel pairs {p10, p11}:
// synchronous write port, asynchronous read port, contents never cleared.
module line_pair_buf
    import output_serializer_pkg::*;
#(
    parameter int PIX_W  = PIX_W_DEFAULT,
    parameter int LINE_W = 16,
    localparam int AW    = col_width(LINE_W)
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [2*PIX_W-1:0]   wr_data,
    input  logic [AW-1:0]        rd_addr,
    output logic [2*PIX_W-1:0]   rd_data
);

    logic [2*PIX_W-1:0] mem [LINE_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/output_serializer.sv
// Serializes 2x2 upscaled quads into a raster pixel stream: top row streams out live,
// bottom row is replayed from a line buffer. Optional macro OUTSER_SOF_EN adds in_sof/out_sof/err_sof.
module output_serializer
    import output_serializer_pkg::*;
#(
    parameter int PIX_W  = PIX_W_DEFAULT,
    parameter int LINE_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_p00,
    input  logic [PIX_W-1:0] in_p01,
    input  logic [PIX_W-1:0] in_p10,
    input  logic [PIX_W-1:0] in_p11,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_pix,
    output logic             out_sol,
    output logic             out_eol
`ifdef OUTSER_SOF_EN
    ,
    input  logic             in_sof,
    output logic             out_sof,
    output logic             err_sof
`endif
);

    localparam int COL_W = col_width(LINE_W);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_W - 1);

    state_t             state;
    state_t             state_nxt;
    logic [COL_W-1:0]   col;
    logic [COL_W-1:0]   col_nxt;
    logic [PIX_W-1:0]   hold;
    logic [2*PIX_W-1:0] rd_pair;

    logic               slot_free;
    logic               accept;
    logic               col_first;
    logic               col_last;

    logic               valid_nxt;
    logic [PIX_W-1:0]   pix_nxt;
    logic               sol_nxt;
    logic               eol_nxt;

    assign slot_free = !out_valid || out_ready;
    assign col_first = (col == '0);
    assign col_last  = (col == COL_LAST);
    assign in_ready  = (state == TOP_A) && slot_free && !rst;
    assign accept    = in_valid && in_ready;

    line_pair_buf #(
        .PIX_W  (PIX_W),
        .LINE_W (LINE_W)
    ) u_lbuf (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (col),
        .wr_data ({in_p10, in_p11}),
        .rd_addr (col),
        .rd_data (rd_pair)
    );

    // Next-state and output-register load decisions; nothing moves unless the slot is free.
    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        valid_nxt = out_valid;
        pix_nxt   = out_pix;
        sol_nxt   = out_sol;
        eol_nxt   = out_eol;
        case (state)
            TOP_A: begin
                if (accept) begin
                    valid_nxt = 1'b1;
                    pix_nxt   = in_p00;
                    sol_nxt   = col_first;
                    eol_nxt   = 1'b0;
                    state_nxt = TOP_B;
                end else if (slot_free) begin
                    valid_nxt = 1'b0;
                end
            end
            TOP_B: begin
                if (slot_free) begin
                    valid_nxt = 1'b1;
                    pix_nxt   = hold;
                    sol_nxt   = 1'b0;
                    eol_nxt   = col_last;
                    if (col_last) begin
                        col_nxt   = '0;
                        state_nxt = BOT_A;
                    end else begin
                        col_nxt   = col + COL_W'(1);
                        state_nxt = TOP_A;
                    end
                end
            end
            BOT_A: begin
                if (slot_free) begin
                    valid_nxt = 1'b1;
                    pix_nxt   = rd_pair[2*PIX_W-1:PIX_W];
                    sol_nxt   = col_first;
                    eol_nxt   = 1'b0;
                    state_nxt = BOT_B;
                end
            end
            BOT_B: begin
                if (slot_free) begin
                    valid_nxt = 1'b1;
                    pix_nxt   = rd_pair[PIX_W-1:0];
                    sol_nxt   = 1'b0;
                    eol_nxt   = col_last;
                    if (col_last) begin
                        col_nxt   = '0;
                        state_nxt = TOP_A;
                    end else begin
                        col_nxt   = col + COL_W'(1);
                        state_nxt = BOT_A;
                    end
                end
            end
            default: begin
                state_nxt = TOP_A;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= TOP_A;
            col       <= '0;
            out_valid <= 1'b0;
            out_pix   <= '0;
            out_sol   <= 1'b0;
            out_eol   <= 1'b0;
        end else begin
            state     <= state_nxt;
            col       <= col_nxt;
            out_valid <= valid_nxt;
            out_pix   <= pix_nxt;
            out_sol   <= sol_nxt;
            out_eol   <= eol_nxt;
        end
    end

    // The right-hand top pixel waits here for one slot after its quad is accepted.
    always_ff @(posedge clk) begin
        if (accept) begin
            hold <= in_p01;
        end
    end

`ifdef OUTSER_SOF_EN
    logic sof_nxt;
    logic err_nxt;

    always_comb begin
        sof_nxt = out_sof;
        err_nxt = err_sof;
        if (accept) begin
            sof_nxt = in_sof && col_first;
            err_nxt = err_sof || (in_sof && !col_first);
        end else if (slot_free && (state != TOP_A)) begin
            sof_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_sof <= 1'b0;
            err_sof <= 1'b0;
        end else begin
            out_sof <= sof_nxt;
            err_sof <= err_nxt;
        end
    end
`endif

endmodule
